// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_if
// Description : Valid/ready stream bundle for the pipelined adder. The input
//               leg carries operands and carry-in, the output leg carries the
//               sum with its carry and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int Width = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] a;
    logic [Width-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] sum;
    logic             c_out;
    logic             overflow;

    // Producer/consumer side: drives operands and downstream ready
    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : Segmented carry-ripple adder. Each Width/Stages slice is added
//               in its own stage with the carry registered between stages.
//               Operand slices are skewed in, sum slices deskewed out, so one
//               transaction emerges whole after Stages cycles. A single global
//               advance enable implements valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int Width  = 16,
    parameter int Stages = 4
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pipelined_adder_if.slave  bus
);

    localparam int c_SEG_W = Width / Stages;

    if (Width < 1 || Stages < 1 || Stages > Width || (Width % Stages) != 0) begin : g_bad_params
        $error("pipelined_adder: need 1 <= Stages <= Width and Width divisible by Stages");
    end

    logic             w_adv;
    logic [Stages-1:0] w_vld;
    logic [Stages-1:0] w_cy;
    logic [Width-1:0]  w_sum;
    logic              w_c_msb;

    // Whole pipe moves together whenever the output slot is free or draining
    assign w_adv        = !w_vld[Stages-1] || bus.out_ready;
    assign bus.in_ready = w_adv;
    assign bus.out_valid = w_vld[Stages-1];
    assign bus.sum       = w_sum;
    assign bus.c_out     = w_cy[Stages-1];
    assign bus.overflow  = w_c_msb ^ w_cy[Stages-1];

    for (genvar k = 0; k < Stages; k++) begin : g_seg
        localparam int c_DSK = Stages - 1 - k;

        logic [c_SEG_W-1:0] w_a_use;
        logic [c_SEG_W-1:0] w_b_use;
        logic               w_cin_use;
        logic               w_vin;
        logic [c_SEG_W:0]   w_seg;

        logic [c_SEG_W-1:0] r_sg;
        logic               r_cy;
        logic               r_vld;

        if (k == 0) begin : g_first
            assign w_a_use   = bus.a[c_SEG_W-1:0];
            assign w_b_use   = bus.b[c_SEG_W-1:0];
            assign w_cin_use = bus.c_in;
            assign w_vin     = bus.in_valid;
        end else begin : g_skew
            logic [c_SEG_W-1:0] r_a_dly [k];
            logic [c_SEG_W-1:0] r_b_dly [k];

            // Delay operand slice k by k registers so it meets its carry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < k; j++) begin
                        r_a_dly[j] <= '0;
                        r_b_dly[j] <= '0;
                    end
                end else if (w_adv) begin
                    r_a_dly[0] <= bus.a[k*c_SEG_W +: c_SEG_W];
                    r_b_dly[0] <= bus.b[k*c_SEG_W +: c_SEG_W];
                    for (int j = 1; j < k; j++) begin
                        r_a_dly[j] <= r_a_dly[j-1];
                        r_b_dly[j] <= r_b_dly[j-1];
                    end
                end
            end

            assign w_a_use   = r_a_dly[k-1];
            assign w_b_use   = r_b_dly[k-1];
            assign w_cin_use = w_cy[k-1];
            assign w_vin     = w_vld[k-1];
        end

        assign w_seg = {1'b0, w_a_use} + {1'b0, w_b_use} + {{c_SEG_W{1'b0}}, w_cin_use};

        // Stage register: slice sum, carry to the next stage, valid bit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sg  <= '0;
                r_cy  <= 1'b0;
                r_vld <= 1'b0;
            end else if (w_adv) begin
                r_sg  <= w_seg[c_SEG_W-1:0];
                r_cy  <= w_seg[c_SEG_W];
                r_vld <= w_vin;
            end
        end

        assign w_cy[k]  = r_cy;
        assign w_vld[k] = r_vld;

        if (c_DSK == 0) begin : g_nodsk
            assign w_sum[k*c_SEG_W +: c_SEG_W] = r_sg;
        end else begin : g_dsk
            logic [c_SEG_W-1:0] r_dk [c_DSK];

            // Hold slice k back so it lines up with the last slice
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < c_DSK; j++) begin
                        r_dk[j] <= '0;
                    end
                end else if (w_adv) begin
                    r_dk[0] <= r_sg;
                    for (int j = 1; j < c_DSK; j++) begin
                        r_dk[j] <= r_dk[j-1];
                    end
                end
            end

            assign w_sum[k*c_SEG_W +: c_SEG_W] = r_dk[c_DSK-1];
        end

        if (k == Stages - 1) begin : g_msb
            logic r_c_msb;

            // Carry into the MSB recovered as sum ^ a ^ b at that bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_c_msb <= 1'b0;
                end else if (w_adv) begin
                    r_c_msb <= w_seg[c_SEG_W-1] ^ w_a_use[c_SEG_W-1] ^ w_b_use[c_SEG_W-1];
                end
            end

            assign w_c_msb = r_c_msb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Drives three 8-bit adders (Stages = 4, 1, 8) from one shared
//               stimulus stream and checks them against a transaction-level
//               pipeline model plus hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    typedef struct packed {
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tb_in_valid;
    logic [7:0] tb_a;
    logic [7:0] tb_b;
    logic       tb_c_in;
    logic       tb_out_ready;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder_if #(.Width(8)) u_if0 ();
    pipelined_adder_if #(.Width(8)) u_if1 ();
    pipelined_adder_if #(.Width(8)) u_if2 ();

    pipelined_adder #(.Width(8), .Stages(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0.slave));
    pipelined_adder #(.Width(8), .Stages(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));
    pipelined_adder #(.Width(8), .Stages(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(u_if2.slave));

    assign u_if0.in_valid = tb_in_valid;  assign u_if0.a = tb_a;  assign u_if0.b = tb_b;
    assign u_if0.c_in = tb_c_in;          assign u_if0.out_ready = tb_out_ready;
    assign u_if1.in_valid = tb_in_valid;  assign u_if1.a = tb_a;  assign u_if1.b = tb_b;
    assign u_if1.c_in = tb_c_in;          assign u_if1.out_ready = tb_out_ready;
    assign u_if2.in_valid = tb_in_valid;  assign u_if2.a = tb_a;  assign u_if2.b = tb_b;
    assign u_if2.c_in = tb_c_in;          assign u_if2.out_ready = tb_out_ready;

    logic       d_rdy [3];
    logic       d_vld [3];
    logic [7:0] d_sum [3];
    logic       d_co  [3];
    logic       d_ov  [3];

    assign d_rdy[0] = u_if0.in_ready; assign d_vld[0] = u_if0.out_valid; assign d_sum[0] = u_if0.sum;
    assign d_co[0]  = u_if0.c_out;    assign d_ov[0]  = u_if0.overflow;
    assign d_rdy[1] = u_if1.in_ready; assign d_vld[1] = u_if1.out_valid; assign d_sum[1] = u_if1.sum;
    assign d_co[1]  = u_if1.c_out;    assign d_ov[1]  = u_if1.overflow;
    assign d_rdy[2] = u_if2.in_ready; assign d_vld[2] = u_if2.out_valid; assign d_sum[2] = u_if2.sum;
    assign d_co[2]  = u_if2.c_out;    assign d_ov[2]  = u_if2.overflow;

    function automatic int stg(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // Reference result packed as {overflow, c_out, sum}, from plain integer math
    function automatic logic [9:0] ref_res(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int         u;
        int         s;
        logic [7:0] lo;
        u  = int'(a) + int'(b) + int'(ci);
        s  = int'($signed(a)) + int'($signed(b)) + int'(ci);
        lo = u[7:0];
        return {(s > 127 || s < -128), (u > 255), lo};
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d (Stages=%0d) t=%0t: got %0h expected %0h", nm, k, stg(k), $time, act, exp);
        end
    endtask

    // Transaction-level model: each DUT is a row of Stages slots that shift
    // together when the last slot is empty or being taken downstream
    txn_t m_pipe [3][8];
    int   m_acc  [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < 8; j++) m_pipe[k][j] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!m_pipe[k][stg(k)-1].v || tb_out_ready) begin
                    for (int j = 1; j < 8; j++) begin
                        if (j < stg(k)) m_pipe[k][j] <= m_pipe[k][j-1];
                    end
                    m_pipe[k][0] <= {tb_in_valid, tb_a, tb_b, tb_c_in};
                    if (tb_in_valid) m_acc[k] <= m_acc[k] + 1;
                end
            end
        end
    end

    // Per-cycle comparison of every DUT against its model row
    txn_t       cmp_t;
    logic [9:0] cmp_r;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                cmp_t = m_pipe[k][stg(k)-1];
                chk("in_ready", k, 32'(d_rdy[k]), 32'(!cmp_t.v || tb_out_ready));
                chk("out_valid", k, 32'(d_vld[k]), 32'(cmp_t.v));
                if (cmp_t.v) begin
                    cmp_r = ref_res(cmp_t.a, cmp_t.b, cmp_t.ci);
                    chk("result", k, 32'({d_ov[k], d_co[k], d_sum[k]}), 32'(cmp_r));
                end
            end
        end
    end

    // Log of retired results per DUT, with the cycle they left
    logic [9:0] log_res [3][$];
    int         log_cyc [3][$];
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (d_vld[k] && tb_out_ready) begin
                    log_res[k].push_back({d_ov[k], d_co[k], d_sum[k]});
                    log_cyc[k].push_back(cyc);
                end
            end
        end
    end

    task automatic clear_logs();
        for (int k = 0; k < 3; k++) begin
            log_res[k].delete();
            log_cyc[k].delete();
        end
    endtask

    task automatic send(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
        @(posedge clk); #1;
        tb_in_valid = v;
        tb_a        = a;
        tb_b        = b;
        tb_c_in     = ci;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    logic [9:0] exp_q [16];
    logic [7:0] ra, rb;
    logic       rc;
    int         acc0 [3];

    initial begin
        rst_n        = 1'b0;
        tb_in_valid  = 1'b0;
        tb_a         = 8'h00;
        tb_b         = 8'h00;
        tb_c_in      = 1'b0;
        tb_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) m_acc[k] = 0;

        // Reset state
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 32'(d_vld[k]), 32'd0);
            chk("rst_sum", k, 32'(d_sum[k]), 32'd0);
            chk("rst_cout", k, 32'(d_co[k]), 32'd0);
            chk("rst_ovf", k, 32'(d_ov[k]), 32'd0);
            chk("rst_ready", k, 32'(d_rdy[k]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single transaction: latency equals Stages for every DUT
        send(1'b1, 8'h0F, 8'h01, 1'b0);
        send(1'b0, 8'h00, 8'h00, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("lat_valid", k, 32'(d_vld[k]), 32'(c == stg(k)));
                if (c == stg(k)) chk("lat_result", k, 32'({d_ov[k], d_co[k], d_sum[k]}), 32'({1'b0, 1'b0, 8'h10}));
            end
        end

        // Carry ripple, signed overflow, and full wrap
        clear_logs();
        send(1'b1, 8'hFF, 8'h00, 1'b1);
        send(1'b1, 8'h7F, 8'h01, 1'b0);
        send(1'b1, 8'h80, 8'h80, 1'b0);
        send(1'b0, 8'h00, 8'h00, 1'b0);
        for (int w = 0; w < 20; w++) begin
            @(posedge clk); #1;
            if (log_res[0].size() >= 3 && log_res[1].size() >= 3 && log_res[2].size() >= 3) break;
        end
        for (int k = 0; k < 3; k++) begin
            chk("dir_count", k, 32'(log_res[k].size()), 32'd3);
            if (log_res[k].size() >= 3) begin
                chk("dir_ff_00_c1", k, 32'(log_res[k][0]), 32'({1'b0, 1'b1, 8'h00}));
                chk("dir_7f_01", k, 32'(log_res[k][1]), 32'({1'b1, 1'b0, 8'h80}));
                chk("dir_80_80", k, 32'(log_res[k][2]), 32'({1'b1, 1'b1, 8'h00}));
            end
        end
        idle(10);

        // Back-to-back random stream, out_ready held high
        clear_logs();
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp_q[i] = ref_res(ra, rb, rc);
            send(1'b1, ra, rb, rc);
        end
        idle(12);
        for (int k = 0; k < 3; k++) begin
            chk("stream_count", k, 32'(log_res[k].size()), 32'd16);
            if (log_res[k].size() == 16) begin
                chk("stream_gapless", k, 32'(log_cyc[k][15] - log_cyc[k][0]), 32'd15);
                for (int i = 0; i < 16; i++) chk("stream_order", k, 32'(log_res[k][i]), 32'(exp_q[i]));
            end
        end

        // Backpressure: out_ready low for 3 cycles in the middle of a stream
        clear_logs();
        for (int k = 0; k < 3; k++) acc0[k] = m_acc[k];
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            tb_out_ready = !(i >= 6 && i < 9);
            if (i >= 6 && i < 9) begin
                #1;
                chk("stall_ready", 0, 32'(d_rdy[0]), 32'd0);
                chk("stall_ready", 1, 32'(d_rdy[1]), 32'd0);
            end
        end
        send(1'b0, 8'h00, 8'h00, 1'b0);
        tb_out_ready = 1'b1;
        idle(15);
        for (int k = 0; k < 3; k++) begin
            chk("bp_no_loss", k, 32'(log_res[k].size()), 32'(m_acc[k] - acc0[k]));
        end

        // Reset with transactions in flight
        send(1'b1, 8'h11, 8'h22, 1'b0);
        send(1'b1, 8'h33, 8'h44, 1'b1);
        send(1'b1, 8'h55, 8'h66, 1'b0);
        send(1'b0, 8'h00, 8'h00, 1'b0);
        chk("pre_rst_valid", 1, 32'(d_vld[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        clear_logs();
        for (int k = 0; k < 3; k++) begin
            chk("arst_valid", k, 32'(d_vld[k]), 32'd0);
            chk("arst_data", k, 32'({d_ov[k], d_co[k], d_sum[k]}), 32'd0);
            chk("arst_ready", k, 32'(d_rdy[k]), 32'd1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(12);
        for (int k = 0; k < 3; k++) chk("no_stale", k, 32'(log_res[k].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined carry-ripple adder: operands are split into equal segments, each segment is added in its own pipeline stage, and the carry is registered between stages. It supersedes the purely combinational ripple adder in the datapath wherever wide additions must close timing. A valid/ready handshake with backpressure lets it sit directly between streaming producers and consumers.

## Interface
- `Width`, default 16: operand and sum width in bits; must be ≥ 1.
- `Stages`, default 4: number of pipeline stages. Must satisfy 1 ≤ `Stages` ≤ `Width` and `Width % Stages == 0`, checked by elaboration-time assertion. `SegWidth = Width / Stages`.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `a`, `b` and `c_in` carry a transaction.
- `in_ready` output 1: block accepts a transaction this cycle.
- `a` input `Width`: operand A, unsigned or two's complement.
- `b` input `Width`: operand B.
- `c_in` input 1: carry into bit 0.
- `out_valid` output 1: `sum`, `c_out` and `overflow` hold a result.
- `out_ready` input 1: downstream accepts the result this cycle.
- `sum` output `Width`: `(a + b + c_in) mod 2^Width`.
- `c_out` output 1: carry out of bit `Width-1`, the unsigned overflow.
- `overflow` output 1: two's-complement overflow, equal to the carry into the MSB XOR the carry out of the MSB.

## Operation
- Global advance enable: `adv = !out_valid || out_ready`. `in_ready = adv`, which is a combinational function of `out_ready` and registered `out_valid`.
- A transaction is accepted when `in_valid && in_ready`. When `adv = 1`, every stage shifts forward one position. Stage 0 loads the new transaction, or a bubble if `in_valid = 0`.
- Stage k (0 ≤ k < `Stages`):
  - Adds segment k, bits `[k*SegWidth +: SegWidth]`, of its delayed `a` and `b` copies to the carry registered by stage k-1. Stage 0 uses `c_in`.
  - Registers the segment sum, the carry out and its valid bit.
- Skew and deskew:
  - Operand segment k is delayed k registers before use.
  - Sum segment k is delayed `Stages-1-k` registers after use.
  - As a result, all segments of one transaction emerge in the same cycle.
- The last stage also registers the carry into the MSB, which is used to compute `overflow`.
- When `adv = 0`, every register holds its value and output signals stay stable, as AXI-style valid/ready requires.
- Bubbles propagate with valid = 0. Bubbles are not collapsed.
- `Stages = 1` reduces to a registered full-width ripple adder.

## Timing
- Latency is exactly `Stages` cycles from the accepting edge to `out_valid = 1`, provided no stall occurs in between.
- Throughput is one transaction per cycle when `out_ready` is held at 1.
- Reset state (asynchronous, while `rst_n = 0`):
  - Every valid bit, `out_valid`, `sum`, `c_out`, `overflow` and all data and carry registers are 0.
  - `in_ready` is 1, because `out_valid = 0`.
- Reset asserted mid-operation discards all in-flight transactions immediately. No output is produced for them after `rst_n` rises.
- Stall and accept in the same cycle:
  - If `out_valid && !out_ready`, then `in_ready = 0` and the input is not sampled.
  - If `out_valid && out_ready && in_valid`, the output retires and a new input enters on the same edge.
- Wrap-around: the sum is modulo `2^Width`. `c_out` and `overflow` are reported per transaction and never sticky.

## Test plan
- Reset and pipeline fill, `Width=8`, `Stages=4`:
  - `rst_n = 0`: all outputs are 0 and `in_ready = 1`.
  - Release reset, then drive `a=0x0F`, `b=0x01`, `c_in=0` for one cycle.
  - Required: `out_valid` rises exactly 4 cycles later with `sum=0x10`, `c_out=0`, `overflow=0`.
- Full carry ripple across all stages:
  - Drive `a=0xFF`, `b=0x00`, `c_in=1`.
  - Required: `sum=0x00`, `c_out=1`, `overflow=0`.
  - Drive `a=0x7F`, `b=0x01`, `c_in=0`.
  - Required: `sum=0x80`, `c_out=0`, `overflow=1`.
- Streaming:
  - Hold `out_ready=1` and drive 16 back-to-back random transactions.
  - Required: 16 results, in order, with no gaps, each matching the reference `a+b+c_in`.
- Backpressure:
  - While streaming, drop `out_ready` for 3 cycles.
  - Required: `in_ready=0` during the stall, outputs stay stable, no transaction is lost or duplicated, and the stream resumes in order.
- Reset mid-operation:
  - Assert `rst_n=0` with 3 transactions in flight.
  - Required: outputs go to 0 asynchronously and no stale result appears after release.
- Degenerate configurations:
  - `Width=8`, `Stages=1`: latency is 1 cycle and `0x80+0x80` gives `sum=0x00`, `c_out=1`, `overflow=1`.
  - `Width=8`, `Stages=8`: latency is 8 cycles and the same result is produced.
